// File: rtl/compara_colisoes_pkg.sv
// Shared types for the multichannel collision scanner: state codes
// and width helpers for addresses and {x,y} positions.
package compara_colisoes_pkg;

  typedef enum logic [4:0] {
    IDLE           = 5'd0,
    LE_AST         = 5'd1,
    CMP_NAVE       = 5'd2,
    COLIDE_NAVE    = 5'd3,
    VERIFICA_VIDAS = 5'd4,
    LE_TIRO        = 5'd5,
    CMP_TIRO       = 5'd6,
    ACERTO         = 5'd7,
    PROX_TIRO      = 5'd8,
    PROX_AST       = 5'd9,
    FIM            = 5'd10
  } estado_t;

  function automatic int largura_end(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int largura_pos(input int cw);
    return 2 * cw;
  endfunction

endpackage

// File: rtl/compara_colisoes_multicanal_if.sv
// Asteroid/shot position memory bus: the scanner is master (addresses,
// clear strobes), the memories are slave (registered data, loaded bits).
interface compara_colisoes_multicanal_if #(
  parameter int AW = 4,
  parameter int TW = 2,
  parameter int PW = 8
);
  logic [AW-1:0] endereco_asteroide;
  logic [PW-1:0] dado_asteroide;
  logic          loaded_asteroide;
  logic          we_asteroide;
  logic [TW-1:0] endereco_tiro;
  logic [PW-1:0] dado_tiro;
  logic          loaded_tiro;
  logic          we_tiro;

  modport master (
    output endereco_asteroide, we_asteroide,
    output endereco_tiro, we_tiro,
    input  dado_asteroide, loaded_asteroide,
    input  dado_tiro, loaded_tiro
  );

  modport slave (
    input  endereco_asteroide, we_asteroide,
    input  endereco_tiro, we_tiro,
    output dado_asteroide, loaded_asteroide,
    output dado_tiro, loaded_tiro
  );
endinterface

// File: rtl/compara_colisoes_multicanal_comparador.sv
// Combinational {x,y} position match; with COLISAO_ADJACENTE_EN defined
// positions one step apart on each axis also match.
module comparador_posicao
  import compara_colisoes_pkg::*;
#(
  parameter int COORD_W = 4
) (
  input  logic [2*COORD_W-1:0] a_i,
  input  logic [2*COORD_W-1:0] b_i,
  output logic                 igual_o
);
`ifdef COLISAO_ADJACENTE_EN
  localparam logic [COORD_W:0] UM = (COORD_W+1)'(1);
  logic [COORD_W:0] ax, ay, bx, by, dx, dy;

  // one extra bit so the difference never wraps
  assign ax = {1'b0, a_i[2*COORD_W-1:COORD_W]};
  assign ay = {1'b0, a_i[COORD_W-1:0]};
  assign bx = {1'b0, b_i[2*COORD_W-1:COORD_W]};
  assign by = {1'b0, b_i[COORD_W-1:0]};
  assign dx = (ax >= bx) ? ax - bx : bx - ax;
  assign dy = (ay >= by) ? ay - by : by - ay;
  assign igual_o = (dx <= UM) && (dy <= UM);
`else
  assign igual_o = (a_i == b_i);
`endif
endmodule

// File: rtl/compara_colisoes_multicanal.sv
// Scans every asteroid against the ship and all shots, clearing hits.
// Build option: COLISAO_ADJACENTE_EN widens matches to adjacent cells.
module compara_colisoes_multicanal
  import compara_colisoes_pkg::*;
#(
  parameter int N_ASTEROIDES = 16,
  parameter int N_TIROS      = 4,
  parameter int COORD_W      = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iniciar,
  input  logic [2*COORD_W-1:0]     posicao_nave,
  input  logic                     ha_vidas,
  compara_colisoes_multicanal_if.master mem,
  output logic                     enable_decrementador,
  output logic                     incrementa_pontos,
  output logic                     fim,
  output logic                     game_over,
  output logic                     ocupado,
  output logic [4:0]               db_estado
);
  localparam int AW = largura_end(N_ASTEROIDES);
  localparam int TW = largura_end(N_TIROS);
  localparam int PW = largura_pos(COORD_W);
  localparam logic [AW-1:0] I_ULT = AW'(N_ASTEROIDES - 1);
  localparam logic [TW-1:0] J_ULT = TW'(N_TIROS - 1);

  estado_t       estado_q, estado_d;
  logic [AW-1:0] i_q, i_d;
  logic [TW-1:0] j_q, j_d;
  logic [PW-1:0] ast_q, ast_d;
  logic          go_q, go_d;
  logic          col_nave, col_tiro;
  logic          we_a, we_t;

  comparador_posicao #(.COORD_W(COORD_W)) u_nave (
    .a_i    (mem.dado_asteroide),
    .b_i    (posicao_nave),
    .igual_o(col_nave)
  );

  comparador_posicao #(.COORD_W(COORD_W)) u_tiro (
    .a_i    (mem.dado_tiro),
    .b_i    (ast_q),
    .igual_o(col_tiro)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      ast_q    <= '0;
      go_q     <= 1'b0;
    end else begin
      estado_q <= estado_d;
      i_q      <= i_d;
      j_q      <= j_d;
      ast_q    <= ast_d;
      go_q     <= go_d;
    end
  end

  always_comb begin
    estado_d             = estado_q;
    i_d                  = i_q;
    j_d                  = j_q;
    ast_d                = ast_q;
    go_d                 = go_q;
    we_a                 = 1'b0;
    we_t                 = 1'b0;
    enable_decrementador = 1'b0;
    incrementa_pontos    = 1'b0;
    fim                  = 1'b0;
    unique case (estado_q)
      IDLE: if (iniciar) begin
        i_d      = '0;
        j_d      = '0;
        go_d     = 1'b0;
        estado_d = LE_AST;
      end
      LE_AST: estado_d = CMP_NAVE;
      CMP_NAVE: begin
        // held for the shot compares while the shot bus is re-addressed
        ast_d = mem.dado_asteroide;
        if (!mem.loaded_asteroide) estado_d = PROX_AST;
        else if (col_nave)         estado_d = COLIDE_NAVE;
        else begin
          j_d      = '0;
          estado_d = LE_TIRO;
        end
      end
      COLIDE_NAVE: begin
        we_a                 = 1'b1;
        enable_decrementador = 1'b1;
        estado_d             = VERIFICA_VIDAS;
      end
      VERIFICA_VIDAS: begin
        if (ha_vidas) estado_d = PROX_AST;
        else begin
          go_d     = 1'b1;
          estado_d = FIM;
        end
      end
      LE_TIRO: estado_d = CMP_TIRO;
      CMP_TIRO: begin
        if (mem.loaded_tiro && col_tiro) estado_d = ACERTO;
        else                             estado_d = PROX_TIRO;
      end
      ACERTO: begin
        we_a              = 1'b1;
        we_t              = 1'b1;
        incrementa_pontos = 1'b1;
        estado_d          = PROX_AST;
      end
      PROX_TIRO: begin
        if (j_q == J_ULT) estado_d = PROX_AST;
        else begin
          j_d      = j_q + 1'b1;
          estado_d = LE_TIRO;
        end
      end
      PROX_AST: begin
        if (i_q == I_ULT) estado_d = FIM;
        else begin
          i_d      = i_q + 1'b1;
          estado_d = LE_AST;
        end
      end
      FIM: begin
        fim      = 1'b1;
        estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  assign mem.endereco_asteroide = i_q;
  assign mem.endereco_tiro      = j_q;
  assign mem.we_asteroide       = we_a;
  assign mem.we_tiro            = we_t;
  assign game_over              = go_q;
  assign ocupado                = (estado_q != IDLE);
  assign db_estado              = estado_q;
endmodule

// File: tb/tb_compara_colisoes_multicanal.sv
// Random and directed scans against a trace model built from the scan rules.
module tb_compara_colisoes_multicanal;
  import compara_colisoes_pkg::*;

  localparam int NA = 4;
  localparam int NT = 2;
  localparam int CW = 4;
  localparam int PW = 8;
  localparam int AW = 2;
  localparam int TW = 1;

  typedef struct packed {
    logic [4:0] st;
    logic [1:0] ea;
    logic       et;
    logic       wa;
    logic       wt;
    logic       dec;
    logic       inc;
    logic       fi;
    logic       go;
    logic       oc;
  } obs_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          iniciar = 1'b0;
  logic          ha_vidas = 1'b0;
  logic [PW-1:0] posicao_nave = '0;
  logic          enable_decrementador, incrementa_pontos;
  logic          fim, game_over, ocupado;
  logic [4:0]    db_estado;

  compara_colisoes_multicanal_if #(.AW(AW), .TW(TW), .PW(PW)) mem_if ();

  compara_colisoes_multicanal #(
    .N_ASTEROIDES(NA), .N_TIROS(NT), .COORD_W(CW)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .iniciar             (iniciar),
    .posicao_nave        (posicao_nave),
    .ha_vidas            (ha_vidas),
    .mem                 (mem_if),
    .enable_decrementador(enable_decrementador),
    .incrementa_pontos   (incrementa_pontos),
    .fim                 (fim),
    .game_over           (game_over),
    .ocupado             (ocupado),
    .db_estado           (db_estado)
  );

  always #5 clock = ~clock;

  logic [PW-1:0] cfg_ap[NA];
  logic          cfg_al[NA];
  logic [PW-1:0] cfg_tp[NT];
  logic          cfg_tl[NT];
  logic          carrega = 1'b0;
  logic [PW-1:0] m_ap[NA];
  logic          m_al[NA];
  logic [PW-1:0] m_tp[NT];
  logic          m_tl[NT];

  always @(posedge clock) begin
    if (carrega) begin
      for (int k = 0; k < NA; k++) begin
        m_ap[k] <= cfg_ap[k];
        m_al[k] <= cfg_al[k];
      end
      for (int k = 0; k < NT; k++) begin
        m_tp[k] <= cfg_tp[k];
        m_tl[k] <= cfg_tl[k];
      end
    end else begin
      if (mem_if.we_asteroide) m_al[mem_if.endereco_asteroide] <= 1'b0;
      if (mem_if.we_tiro)      m_tl[mem_if.endereco_tiro]      <= 1'b0;
    end
    mem_if.dado_asteroide   <= m_ap[mem_if.endereco_asteroide];
    mem_if.loaded_asteroide <= m_al[mem_if.endereco_asteroide];
    mem_if.dado_tiro        <= m_tp[mem_if.endereco_tiro];
    mem_if.loaded_tiro      <= m_tl[mem_if.endereco_tiro];
  end

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  bit   chk_en = 0;
  bit   go_m = 0;
  int   cyc, fim_cyc, n_dec, n_inc, n_wa, wa_addr, hit_a, hit_t, max_ea;
  int   exp_len;

  function automatic obs_t cur();
    obs_t o;
    o.st  = db_estado;
    o.ea  = mem_if.endereco_asteroide;
    o.et  = mem_if.endereco_tiro;
    o.wa  = mem_if.we_asteroide;
    o.wt  = mem_if.we_tiro;
    o.dec = enable_decrementador;
    o.inc = incrementa_pontos;
    o.fi  = fim;
    o.go  = game_over;
    o.oc  = ocupado;
    return o;
  endfunction

  function automatic bit casa(input logic [7:0] a, input logic [7:0] b);
`ifdef COLISAO_ADJACENTE_EN
    int dx, dy;
    dx = int'(a[7:4]) - int'(b[7:4]);
    dy = int'(a[3:0]) - int'(b[3:0]);
    return (dx >= -1) && (dx <= 1) && (dy >= -1) && (dy <= 1);
`else
    return a == b;
`endif
  endfunction

  task automatic push(input int st, input int ea, input int et,
                      input bit wa, input bit wt, input bit dec,
                      input bit inc, input bit fi);
    obs_t o;
    o.st  = 5'(st);
    o.ea  = 2'(ea);
    o.et  = 1'(et);
    o.wa  = wa;
    o.wt  = wt;
    o.dec = dec;
    o.inc = inc;
    o.fi  = fi;
    o.go  = go_m;
    o.oc  = (st != 0);
    exp_q.push_back(o);
  endtask

  // Expected per-cycle trace of one whole scan, from the game rules.
  task automatic monta();
    logic [PW-1:0] ap[NA];
    logic          al[NA];
    logic [PW-1:0] tp[NT];
    logic          tl[NT];
    int jv, last_i;
    bit parou;
    for (int k = 0; k < NA; k++) begin
      ap[k] = cfg_ap[k];
      al[k] = cfg_al[k];
    end
    for (int k = 0; k < NT; k++) begin
      tp[k] = cfg_tp[k];
      tl[k] = cfg_tl[k];
    end
    jv = 0;
    last_i = 0;
    parou = 0;
    go_m = 0;
    for (int i = 0; i < NA && !parou; i++) begin
      last_i = i;
      push(1, i, jv, 0, 0, 0, 0, 0);
      push(2, i, jv, 0, 0, 0, 0, 0);
      if (al[i] && casa(ap[i], posicao_nave)) begin
        push(3, i, jv, 1, 0, 1, 0, 0);
        al[i] = 0;
        push(4, i, jv, 0, 0, 0, 0, 0);
        if (!ha_vidas) begin
          go_m = 1;
          parou = 1;
        end
      end else if (al[i]) begin
        jv = 0;
        for (int k = 0; k < NT; k++) begin
          jv = k;
          push(5, i, jv, 0, 0, 0, 0, 0);
          push(6, i, jv, 0, 0, 0, 0, 0);
          if (tl[k] && casa(tp[k], ap[i])) begin
            push(7, i, jv, 1, 1, 0, 1, 0);
            tl[k] = 0;
            al[i] = 0;
            break;
          end
          push(8, i, jv, 0, 0, 0, 0, 0);
        end
      end
      if (!parou) push(9, i, jv, 0, 0, 0, 0, 0);
    end
    push(10, last_i, jv, 0, 0, 0, 0, 1);
    push(0, last_i, jv, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic limpa();
    for (int k = 0; k < NA; k++) begin
      cfg_ap[k] = '0;
      cfg_al[k] = 1'b0;
    end
    for (int k = 0; k < NT; k++) begin
      cfg_tp[k] = '0;
      cfg_tl[k] = 1'b0;
    end
    posicao_nave = 8'hFF;
  endtask

  task automatic carregar();
    @(posedge clock); #1;
    carrega = 1'b1;
    @(posedge clock); #1;
    carrega = 1'b0;
  endtask

  task automatic run_scan();
    int budget;
    carregar();
    monta();
    exp_len = exp_q.size();
    iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    chk_en = 1'b1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 300) begin
      @(posedge clock); #1;
      iniciar = (exp_q.size() > 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      budget++;
    end
    chk_en = 1'b0;
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL scan_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    obs_t e, g;
    int   adj_exp;
    int   budget;
    bit   prev_idle;
    prev_idle = 1;
    {cyc, n_dec, n_inc, n_wa, max_ea} = '0;
    {fim_cyc, wa_addr, hit_a, hit_t} = {-1, -1, -1, -1};

    fork
      forever begin
        @(negedge clock);
        if (chk_en && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          g = cur();
          if (e.st == 5'd1 && prev_idle) begin
            cyc = 0; n_dec = 0; n_inc = 0; n_wa = 0; max_ea = 0;
            fim_cyc = -1; wa_addr = -1; hit_a = -1; hit_t = -1;
          end
          prev_idle = (e.st == 5'd0);
          checks++;
          if (g !== e) begin
            errors++;
            $display("FAIL cycle %0d: got %h expected %h", cyc, g, e);
          end
          if (g.fi) fim_cyc = cyc;
          if (g.dec) n_dec++;
          if (g.inc) n_inc++;
          if (g.wa) begin
            n_wa++;
            wa_addr = int'(g.ea);
          end
          if (g.wa && g.wt) begin
            hit_a = int'(g.ea);
            hit_t = int'(g.et);
          end
          if (int'(g.ea) > max_ea) max_ea = int'(g.ea);
          cyc++;
        end
      end
    join_none

    limpa();
    #12;
    chk("reset_outputs", int'(cur()), 0);
    @(negedge clock);
    reset = 1'b0;

    limpa();
    run_scan();
    chk("empty_trace_len", exp_len, 14);
    chk("empty_fim_cycle", fim_cyc, 12);
    chk("empty_writes", n_wa + n_dec + n_inc, 0);

    limpa();
    cfg_ap[2] = 8'h55; cfg_al[2] = 1'b1;
    posicao_nave = 8'h55; ha_vidas = 1'b1;
    run_scan();
    chk("nave_dec", n_dec, 1);
    chk("nave_we_addr", wa_addr, 2);
    chk("nave_fim_cycle", fim_cyc, 14);
    chk("nave_game_over", int'(game_over), 0);

    ha_vidas = 1'b0;
    run_scan();
    chk("gover_set", int'(game_over), 1);
    chk("gover_fim_cycle", fim_cyc, 10);
    chk("gover_max_addr", max_ea, 2);
    limpa();
    run_scan();
    chk("gover_cleared", int'(game_over), 0);

    limpa();
    cfg_ap[1] = 8'h37; cfg_al[1] = 1'b1;
    cfg_tp[1] = 8'h37; cfg_tl[1] = 1'b1;
    cfg_tp[0] = 8'h00; cfg_tl[0] = 1'b1;
    run_scan();
    chk("hit_ast_addr", hit_a, 1);
    chk("hit_tiro_addr", hit_t, 1);
    chk("hit_score", n_inc, 1);
    chk("hit_shot0_kept", int'(m_tl[0]), 1);
    chk("hit_shot1_gone", int'(m_tl[1]), 0);

    limpa();
    cfg_ap[0] = 8'h37; cfg_al[0] = 1'b1;
    cfg_ap[1] = 8'h37; cfg_al[1] = 1'b1;
    cfg_tp[0] = 8'h37; cfg_tl[0] = 1'b1;
    run_scan();
    chk("dup_score", n_inc, 1);
    chk("dup_ast0_gone", int'(m_al[0]), 0);
    chk("dup_ast1_kept", int'(m_al[1]), 1);

    limpa();
    cfg_ap[0] = 8'h44; cfg_al[0] = 1'b1;
    posicao_nave = 8'h53; ha_vidas = 1'b1;
`ifdef COLISAO_ADJACENTE_EN
    adj_exp = 1;
`else
    adj_exp = 0;
`endif
    run_scan();
    chk("adjacent_dec", n_dec, adj_exp);

    limpa();
    cfg_ap[0] = 8'h11; cfg_al[0] = 1'b1;
    cfg_tp[0] = 8'h99; cfg_tl[0] = 1'b1;
    carregar();
    iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    budget = 0;
    do begin
      @(negedge clock);
      budget++;
    end while (db_estado != 5'd6 && budget < 50);
    chk("reach_cmp_tiro", int'(db_estado), 6);
    #2 reset = 1'b1;
    #1 chk("async_reset", int'(cur()), 0);
    @(negedge clock);
    reset = 1'b0;

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < NA; k++) begin
        cfg_ap[k] = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
        cfg_al[k] = 1'($urandom_range(0, 1));
      end
      for (int k = 0; k < NT; k++) begin
        cfg_tp[k] = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
        cfg_tl[k] = 1'($urandom_range(0, 1));
      end
      posicao_nave = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      ha_vidas = 1'($urandom_range(0, 1));
      run_scan();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
